// File: rtl/mw_power_sched_pkg.sv
// Shared types and constants for the microwave power scheduler and the microwave top.
// Holds the FSM state encoding, the level limits and the keypad decode helpers.
package mw_power_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_RUN   = 2'd2,
    ST_BEEP  = 2'd3
  } state_t;

  localparam logic [3:0] LEVEL_MAX   = 4'd10;
  localparam logic [3:0] LEVEL_RESET = 4'd10;

  function automatic logic is_onehot10(input logic [9:0] keys);
    return (keys != '0) && ((keys & (keys - 10'd1)) == '0);
  endfunction

  // Digit 0 selects full power, so it maps to LEVEL_MAX rather than 0.
  function automatic logic [3:0] key_level(input logic [9:0] keys);
    logic [3:0] lvl;
    lvl = LEVEL_MAX;
    for (int d = 1; d < 10; d++) begin
      if (keys[d]) lvl = 4'(d);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/mw_power_sched_if.sv
// Front-end bus between the timer/keypad logic and the power scheduler.
// master drives the keypad/timer inputs, slave is the scheduler itself.
interface mw_power_sched_if;
  logic       tick;
  logic [9:0] kbd;
  logic       pwr_keyn;
  logic       cook_run;
  logic       cook_done;
  logic       door_closed;
  logic       mag_on;
  logic [3:0] level;
  logic       level_entry;
  logic       beep;

  modport master (
    output tick, kbd, pwr_keyn, cook_run, cook_done, door_closed,
    input  mag_on, level, level_entry, beep
  );

  modport slave (
    input  tick, kbd, pwr_keyn, cook_run, cook_done, door_closed,
    output mag_on, level, level_entry, beep
  );
endinterface

// File: rtl/mw_power_sched_duty_slot_counter.sv
// Mod-WINDOW slot counter that positions the magnetron within its duty window.
// Cleared whenever cooking is not running so every resume starts at slot 0.
module duty_slot_counter #(
  parameter int WINDOW = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_tick,
  output logic [3:0] o_slot
);

  logic [3:0] r_slot;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_slot <= 4'd0;
    end else if (i_clr) begin
      r_slot <= 4'd0;
    end else if (i_en && i_tick) begin
      r_slot <= (r_slot == 4'(WINDOW - 1)) ? 4'd0 : r_slot + 4'd1;
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/mw_power_sched.sv
// Magnetron power-level scheduler: level entry, duty-window time slicing and
// the completion beeper, all driven from the timer status and keypad.
module mw_power_sched
  import mw_power_sched_pkg::*;
#(
  parameter int WINDOW    = 10,
  parameter int BEEP_SECS = 3
) (
  input  logic            clk,
  input  logic            rstn,
  mw_power_sched_if.slave bus
);

  localparam int BW = $clog2(BEEP_SECS + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [9:0]      r_kbd_prev;
  logic            r_pwr_prev;
  logic [3:0]      r_level;
  logic [BW-1:0]   r_beep_cnt;
  logic            r_mag_on;
  logic            r_beep;
  logic            r_level_entry;
  logic [3:0]      w_slot;
  logic            w_key_evt;
  logic            w_pwr_evt;
  logic            w_level_ld;
  logic            w_silence;
  logic            w_beep_expired;

  assign w_key_evt = is_onehot10(bus.kbd) && (r_kbd_prev == '0);
  assign w_pwr_evt = !bus.pwr_keyn && r_pwr_prev;
  assign w_silence = w_key_evt || w_pwr_evt || !bus.door_closed;
  assign w_beep_expired = bus.tick && (r_beep_cnt == BW'(BEEP_SECS - 1));

  duty_slot_counter #(.WINDOW(WINDOW)) u_slot (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (r_state != ST_RUN),
    .i_en   (bus.door_closed),
    .i_tick (bus.tick),
    .o_slot (w_slot)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_kbd_prev <= '0;
      r_pwr_prev <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_kbd_prev <= bus.kbd;
      r_pwr_prev <= bus.pwr_keyn;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_level_ld  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cook_run)  w_state_nxt = ST_RUN;
        else if (w_pwr_evt) w_state_nxt = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (bus.cook_run) begin
          w_state_nxt = ST_RUN;
        end else if (w_key_evt) begin
          w_level_ld  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_pwr_evt) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.cook_done)     w_state_nxt = ST_BEEP;
        else if (!bus.cook_run) w_state_nxt = ST_IDLE;
      end
      ST_BEEP: begin
        if (bus.cook_run)         w_state_nxt = ST_RUN;
        else if (w_silence)       w_state_nxt = ST_IDLE;
        else if (w_beep_expired)  w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_level <= LEVEL_RESET;
    end else if (w_level_ld) begin
      r_level <= key_level(bus.kbd);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beep_cnt <= '0;
    end else if (r_state != ST_BEEP) begin
      r_beep_cnt <= '0;
    end else if (bus.tick) begin
      r_beep_cnt <= r_beep_cnt + BW'(1);
    end
  end

  // cook_done forces the magnetron off on its own edge, even mid-window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mag_on      <= 1'b0;
      r_beep        <= 1'b0;
      r_level_entry <= 1'b0;
    end else begin
      r_mag_on      <= (r_state == ST_RUN) && bus.cook_run && bus.door_closed &&
                       !bus.cook_done && (w_slot < r_level);
      r_beep        <= (r_state == ST_BEEP);
      r_level_entry <= (r_state == ST_ENTRY);
    end
  end

  assign bus.mag_on      = r_mag_on;
  assign bus.beep        = r_beep;
  assign bus.level_entry = r_level_entry;
  assign bus.level       = r_level;

endmodule

// File: tb/tb_mw_power_sched.sv
// Scoreboard bench for mw_power_sched: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model of the scheduler rules.
module tb_mw_power_sched;

  localparam int WIN  = 10;
  localparam int BSEC = 3;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_RUN   = 2;
  localparam int M_BEEP  = 3;

  typedef struct {
    string      name;
    logic       mag;
    logic       bp;
    logic       ent;
    logic [3:0] lvl;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mw_power_sched_if bus();

  mw_power_sched #(.WINDOW(WIN), .BEEP_SECS(BSEC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  event sb_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: elapsed door-closed seconds in the current run, beep ticks.
  int m_mode, m_secs, m_bticks, m_level;
  bit m_kprev_zero, m_pprev;

  task automatic model_reset();
    m_mode = M_IDLE; m_secs = 0; m_bticks = 0; m_level = 10;
    m_kprev_zero = 1'b1; m_pprev = 1'b1;
  endtask

  task automatic drive_idle();
    bus.tick = 1'b0; bus.kbd = '0; bus.pwr_keyn = 1'b1;
    bus.cook_run = 1'b0; bus.cook_done = 1'b0; bus.door_closed = 1'b1;
  endtask

  task automatic cyc(input string nm, input bit t = 0, input logic [9:0] k = '0,
                     input bit pk = 1, input bit run = 0, input bit done = 0,
                     input bit door = 1);
    exp_t e;
    bit   key, pwr;
    int   digit, nxt;
    bus.tick = t; bus.kbd = k; bus.pwr_keyn = pk;
    bus.cook_run = run; bus.cook_done = done; bus.door_closed = door;

    key   = (k != 0) && m_kprev_zero && ($countones(k) == 1);
    pwr   = !pk && m_pprev;
    digit = 10;
    for (int d = 1; d < 10; d++) if (k[d]) digit = d;

    e.name = nm;
    e.mag  = (m_mode == M_RUN) && run && door && !done && ((m_secs % WIN) < m_level);
    e.bp   = (m_mode == M_BEEP);
    e.ent  = (m_mode == M_ENTRY);

    nxt = m_mode;
    if (m_mode == M_IDLE) begin
      if (run) nxt = M_RUN;
      else if (pwr) nxt = M_ENTRY;
    end else if (m_mode == M_ENTRY) begin
      if (run) nxt = M_RUN;
      else if (key) begin m_level = digit; nxt = M_IDLE; end
      else if (pwr) nxt = M_IDLE;
    end else if (m_mode == M_RUN) begin
      if (done) nxt = M_BEEP;
      else if (!run) nxt = M_IDLE;
    end else begin
      if (run) nxt = M_RUN;
      else if (key || pwr || !door) nxt = M_IDLE;
      else if (t && (m_bticks + 1 >= BSEC)) nxt = M_IDLE;
    end

    if (m_mode != M_RUN) m_secs = 0;
    else if (door && t) m_secs++;
    if (m_mode != M_BEEP) m_bticks = 0;
    else if (t) m_bticks++;

    m_mode = nxt;
    e.lvl  = 4'(m_level);
    m_kprev_zero = (k == 0);
    m_pprev      = pk;

    @(posedge clk);
    #1;
    sb_q.push_back(e);
  endtask

  task automatic push_reset_check(input string nm);
    exp_t e;
    e.name = nm; e.mag = 1'b0; e.bp = 1'b0; e.ent = 1'b0; e.lvl = 4'd10;
    sb_q.push_back(e);
    ->sb_ev;
  endtask

  initial begin
    forever begin
      @(negedge clk or sb_ev);
      while (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        n_tests++;
        if (bus.mag_on !== mon_e.mag || bus.beep !== mon_e.bp ||
            bus.level_entry !== mon_e.ent || bus.level !== mon_e.lvl) begin
          n_fail++;
          $display("FAIL %s @%0t: got mag=%b beep=%b entry=%b level=%0d, want mag=%b beep=%b entry=%b level=%0d",
                   mon_e.name, $time, bus.mag_on, bus.beep, bus.level_entry, bus.level,
                   mon_e.mag, mon_e.bp, mon_e.ent, mon_e.lvl);
        end
      end
    end
  end

  initial begin
    bit         tprev, run_r, door_r;
    logic [9:0] kr;
    int         r;

    rstn = 1'b0;
    drive_idle();
    model_reset();
    #12;
    push_reset_check("reset_state");
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc(.nm("idle"));

    // Level entry with key 3, then 20 ticks of cooking.
    cyc(.nm("pwr_press"), .pk(0));
    cyc(.nm("pwr_hold"), .pk(0));
    cyc(.nm("pwr_rel"));
    cyc(.nm("key3"), .k(10'd8));
    cyc(.nm("key3_hold"), .k(10'd8));
    cyc(.nm("key3_rel"));
    cyc(.nm("run_start"), .run(1));
    for (int i = 0; i < 20; i++) begin
      cyc(.nm("l3_tick"), .t(1), .run(1));
      cyc(.nm("l3_gap"), .run(1));
    end
    cyc(.nm("l3_pause"));

    // Digit zero, double power cancel, multi-hot ignored.
    cyc(.nm("pwr_a"), .pk(0));
    cyc(.nm("pwr_a_rel"));
    cyc(.nm("key0"), .k(10'd1));
    cyc(.nm("key0_rel"));
    cyc(.nm("pwr_b"), .pk(0));
    cyc(.nm("pwr_b_rel"));
    cyc(.nm("pwr_c"), .pk(0));
    cyc(.nm("pwr_c_rel"));
    cyc(.nm("pwr_d"), .pk(0));
    cyc(.nm("pwr_d_rel"));
    cyc(.nm("multihot"), .k(10'b0000000110));
    cyc(.nm("multihot_hold"), .k(10'b0000000110));
    cyc(.nm("multihot_rel"));
    cyc(.nm("pwr_exit"), .pk(0));
    cyc(.nm("pwr_exit_rel"));
    cyc(.nm("idle2"));

    // Door open mid-run at level 10.
    cyc(.nm("door_run"), .run(1));
    for (int i = 0; i < 4; i++) cyc(.nm("door_tick"), .t(1), .run(1));
    cyc(.nm("door_open"), .run(1), .door(0));
    for (int i = 0; i < 3; i++) cyc(.nm("door_open_tick"), .t(1), .run(1), .door(0));
    cyc(.nm("door_paused"), .door(0));
    cyc(.nm("door_close"));
    cyc(.nm("door_resume"), .run(1));
    for (int i = 0; i < 12; i++) begin
      cyc(.nm("l10_tick"), .t(1), .run(1));
      cyc(.nm("l10_gap"), .run(1));
    end

    // Done with tick on slot wrap, full beep, then early silence with key 5.
    for (int i = 0; i < 7; i++) cyc(.nm("pre_done"), .t(1), .run(1));
    cyc(.nm("done_wrap"), .t(1), .run(1), .done(1));
    for (int i = 0; i < BSEC; i++) begin
      cyc(.nm("beep_gap"));
      cyc(.nm("beep_tick"), .t(1));
    end
    cyc(.nm("beep_off"));
    cyc(.nm("beep_off2"));
    cyc(.nm("run2"), .run(1));
    cyc(.nm("run2_tick"), .t(1), .run(1));
    cyc(.nm("done2"), .run(1), .done(1));
    cyc(.nm("beep2"));
    cyc(.nm("beep2_tick"), .t(1));
    cyc(.nm("key5_silence"), .k(10'd32));
    cyc(.nm("key5_rel"));
    cyc(.nm("after_silence"));

    // Async reset mid-run at level 5.
    cyc(.nm("pwr_e"), .pk(0));
    cyc(.nm("pwr_e_rel"));
    cyc(.nm("key5"), .k(10'd32));
    cyc(.nm("key5_rel2"));
    cyc(.nm("rst_run"), .run(1));
    cyc(.nm("rst_tick"), .t(1), .run(1));
    cyc(.nm("rst_gap"), .run(1));
    @(negedge clk); #1;
    rstn = 1'b0;
    #1;
    drive_idle();
    model_reset();
    push_reset_check("async_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc(.nm("post_reset"));

    // Random traffic.
    tprev = 0; run_r = 0; door_r = 1; kr = '0;
    for (int i = 0; i < 3000; i++) begin
      bit t, pk, dn;
      t  = !tprev && ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 9);
      if (r <= 5)      kr = '0;
      else if (r <= 7) kr = 10'(1) << $urandom_range(0, 9);
      else if (r == 8) kr = (10'(1) << $urandom_range(0, 9)) | (10'(1) << $urandom_range(0, 9));
      pk = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) run_r = !run_r;
      if ($urandom_range(0, 39) == 0) door_r = !door_r;
      dn = ($urandom_range(0, 29) == 0);
      cyc(.nm("random"), .t(t), .k(kr), .pk(pk), .run(run_r), .done(dn), .door(door_r));
      tprev = t;
    end
    drive_idle();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
